jpeg_carry_cmp_pipe: RTL and testbench
======================================

// Module: jpeg_carry_cmp_pipe
// PURPOSE
//  Multi-channel W-bit carry-chain unit for the JPEG datapath (quantiser/Huffman compare cones).
//  Per channel, computes a+b+cin, unsigned a>b, a==b and the sum's parity.
//  The carry/majority chain is split into STAGES registered segments to close timing.
//  A valid/ready interface wraps the pipeline; all CH channels advance in lockstep.
// PARAMETERS
//  W       16  operand width per channel (bits); must be a multiple of STAGES
//  CH      4   number of parallel channels
//  STAGES  4   pipeline segments (1..W); latency in cycles
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       reset, synchronous, active-low
//  in_valid   in   1       input beat valid
//  in_ready   out  1       pipeline can accept a beat
//  in_a       in   CH*W    operand A, channel c at [c*W +: W]
//  in_b       in   CH*W    operand B, same packing
//  in_cin     in   CH      carry-in per channel
//  out_valid  out  1       result beat valid
//  out_ready  in   1       downstream accepts the beat
//  out_sum    out  CH*W    sum bits [W-1:0] per channel
//  out_cout   out  CH      carry-out per channel
//  out_gt     out  CH      1 if a>b (unsigned)
//  out_eq     out  CH      1 if a==b
//  out_par    out  CH      XOR-reduce of {cout,sum}
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valid bits, out_valid, out_* data cleared to 0.
//    in_ready is 1 out of reset. Reset mid-flight discards every in-flight beat.
//  - advance = !out_valid || out_ready; in_ready = advance (combinational from out_valid/out_ready).
//  - The input is accepted when in_valid && in_ready. When advance=1, every stage shifts by one;
//    stage 0 loads the accepted beat or a bubble (valid=0). When advance=0, all stages hold.
//  - Stage k (0..STAGES-1) processes bits [k*SEG +: SEG], SEG=W/STAGES: ripple sum/carry using
//    the registered carry from stage k-1 (stage 0 uses cin); unprocessed operand bits travel along.
//  - Compare chain runs LSB to MSB alongside the sum: gt_k = (a>b in seg) | (seg_eq & gt_{k-1});
//    eq_k = seg_eq & eq_{k-1}; initial gt=0, eq=1.
//  - Latency: exactly STAGES cycles from acceptance to out_valid with no stall; throughput 1 beat/cycle.
//  - Output is the last stage register; out_* stay stable while out_valid && !out_ready.
//  - Bubbles never produce out_valid; beat order is preserved; no beat is dropped or duplicated.
//  - Arithmetic is unsigned, modulo 2^W, with the carry exported in out_cout. Wrap example:
//    a=FFFF, b=0001, cin=0 -> sum=0000, cout=1.
//  - STAGES=1 degenerates to a single registered full-width chain; timing rules are unchanged.
// CONFIGURATION
//  - Macro JPEG_CARRY_STATS_EN is the only optional feature.
//  - Defined: adds outputs stat_beats[31:0] (accepted beats) and stat_stall[31:0] (cycles with
//    out_valid && !out_ready). Both are saturating, cleared by reset, and count during the same
//    cycle the event occurs (visible on the next cycle).
//  - Undefined: those ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package jpeg_cone_pkg holds: typedef seg_state_t {sum seg bits, carry, gt, eq, valid};
//    function par_reduce; and localparam SEG derivation with a static assert that W%STAGES==0.
//  - One sub-module jpeg_carry_seg: a combinational SEG-bit ripple sum plus compare, instantiated
//    STAGES*CH times. Pipeline registers and the handshake live in the top level.
// TESTING
//  1. Reset held 3 cycles then released -> out_valid=0, in_ready=1, and every out_* is 0.
//  2. Channel 0: a=1234, b=0FED, cin=1, out_ready=1 -> after 4 cycles sum=2222, cout=0, gt=1, eq=0.
//  3. Wrap case: a=FFFF, b=0001, cin=0 -> sum=0000, cout=1, gt=1, par=1. Equal case: a=b=A5A5,
//     cin=0 -> eq=1, gt=0.
//  4. Stream of 8 back-to-back beats, with out_ready=0 for cycles 5-7 -> in_ready drops, no loss,
//     output order 1..8, data stable while stalled.
//  5. Assert rst_n=0 with 3 beats in flight -> no out_valid afterwards until a new beat is accepted.
//  6. With JPEG_CARRY_STATS_EN, test 4 -> stat_beats=8, stat_stall=3.

Source files
------------

// File: rtl/jpeg_cone_pkg.sv
// Shared types and helpers for the JPEG carry/compare pipeline.
// Default geometry lives here; the top level derives its own segment width from its parameters.
package jpeg_cone_pkg;

  localparam int DEF_W      = 16;
  localparam int DEF_CH     = 4;
  localparam int DEF_STAGES = 4;
  localparam int SEG        = DEF_W / DEF_STAGES;
  localparam int PAR_MAX    = 128;

  // Elaboration-time guard: a negative-width type fails to build if the defaults don't divide evenly.
  localparam bit SEG_DIV_OK = (DEF_W % DEF_STAGES) == 0;
  typedef logic [(SEG_DIV_OK ? 0 : -1):0] seg_div_chk_t;

  typedef struct packed {
    logic [SEG-1:0] sum;
    logic           carry;
    logic           gt;
    logic           eq;
    logic           valid;
  } seg_state_t;

  function automatic logic par_reduce(input logic [PAR_MAX-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/jpeg_carry_seg.sv
// One SEG-bit ripple segment: partial sum with carry plus the LSB-to-MSB compare chain step.
module jpeg_carry_seg
  import jpeg_cone_pkg::*;
#(
  parameter int SEG_W = SEG
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  input  logic             gt_in,
  input  logic             eq_in,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             gt,
  output logic             eq
);

  logic [SEG_W:0] total;
  logic           seg_gt;
  logic           seg_eq;

  assign total  = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  assign sum    = total[SEG_W-1:0];
  assign cout   = total[SEG_W];
  assign seg_gt = a > b;
  assign seg_eq = a == b;
  // A higher segment decides unless it is equal, in which case the lower verdict carries up.
  assign gt     = seg_gt | (seg_eq & gt_in);
  assign eq     = seg_eq & eq_in;

endmodule

// File: rtl/jpeg_carry_cmp_pipe.sv
// Multi-channel pipelined add/compare unit with valid/ready wrapper; all channels move in lockstep.
// Optional macro JPEG_CARRY_STATS_EN adds saturating accepted-beat and stall-cycle counters.
module jpeg_carry_cmp_pipe
  import jpeg_cone_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int CH     = DEF_CH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_a,
  input  logic [CH*W-1:0] in_b,
  input  logic [CH-1:0]   in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_sum,
  output logic [CH-1:0]   out_cout,
  output logic [CH-1:0]   out_gt,
  output logic [CH-1:0]   out_eq,
  output logic [CH-1:0]   out_par
`ifdef JPEG_CARRY_STATS_EN
  ,
  output logic [31:0]     stat_beats,
  output logic [31:0]     stat_stall
`endif
);

  localparam int SEG_W = W / STAGES;

  if ((STAGES < 1) || (W % STAGES != 0)) begin : g_geom_chk
    $error("jpeg_carry_cmp_pipe: W must be a positive multiple of STAGES");
  end

  logic advance;

  // Stage registers: operands travel with the partial sum and chain state.
  logic [CH*W-1:0] a_p   [STAGES];
  logic [CH*W-1:0] b_p   [STAGES];
  logic [CH*W-1:0] sum_p [STAGES];
  logic [CH-1:0]   cy_p  [STAGES];
  logic [CH-1:0]   gt_p  [STAGES];
  logic [CH-1:0]   eq_p  [STAGES];
  logic            vld_p [STAGES];

  logic [CH*W-1:0] a_s   [STAGES];
  logic [CH*W-1:0] b_s   [STAGES];
  logic [CH*W-1:0] sum_s [STAGES];
  logic [CH-1:0]   cy_s  [STAGES];
  logic [CH-1:0]   gt_s  [STAGES];
  logic [CH-1:0]   eq_s  [STAGES];
  logic            vld_s [STAGES];

  logic [SEG_W-1:0] seg_sum [STAGES][CH];
  logic             seg_cy  [STAGES][CH];
  logic             seg_gt  [STAGES][CH];
  logic             seg_eq  [STAGES][CH];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_s[k]   = in_a;
      assign b_s[k]   = in_b;
      assign sum_s[k] = '0;
      assign cy_s[k]  = in_cin;
      assign gt_s[k]  = '0;
      assign eq_s[k]  = '1;
      assign vld_s[k] = in_valid;
    end else begin : g_link
      assign a_s[k]   = a_p[k-1];
      assign b_s[k]   = b_p[k-1];
      assign sum_s[k] = sum_p[k-1];
      assign cy_s[k]  = cy_p[k-1];
      assign gt_s[k]  = gt_p[k-1];
      assign eq_s[k]  = eq_p[k-1];
      assign vld_s[k] = vld_p[k-1];
    end
    for (genvar c = 0; c < CH; c++) begin : g_ch
      jpeg_carry_seg #(.SEG_W(SEG_W)) u_seg (
        .a     (a_s[k][c*W + k*SEG_W +: SEG_W]),
        .b     (b_s[k][c*W + k*SEG_W +: SEG_W]),
        .cin   (cy_s[k][c]),
        .gt_in (gt_s[k][c]),
        .eq_in (eq_s[k][c]),
        .sum   (seg_sum[k][c]),
        .cout  (seg_cy[k][c]),
        .gt    (seg_gt[k][c]),
        .eq    (seg_eq[k][c])
      );
    end
  end

  // Pipeline boundary: every stage shifts together on advance, otherwise all hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= '0;
        gt_p[k]  <= '0;
        eq_p[k]  <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= vld_s[k];
        a_p[k]   <= a_s[k];
        b_p[k]   <= b_s[k];
        sum_p[k] <= sum_s[k];
        for (int c = 0; c < CH; c++) begin
          sum_p[k][c*W + k*SEG_W +: SEG_W] <= seg_sum[k][c];
          cy_p[k][c] <= seg_cy[k][c];
          gt_p[k][c] <= seg_gt[k][c];
          eq_p[k][c] <= seg_eq[k][c];
        end
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_sum   = sum_p[STAGES-1];
  assign out_cout  = cy_p[STAGES-1];
  assign out_gt    = gt_p[STAGES-1];
  assign out_eq    = eq_p[STAGES-1];

  always_comb begin
    out_par = '0;
    for (int c = 0; c < CH; c++) begin
      out_par[c] = par_reduce(PAR_MAX'({cy_p[STAGES-1][c], sum_p[STAGES-1][c*W +: W]}));
    end
  end

`ifdef JPEG_CARRY_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (in_valid && in_ready && (stat_beats != '1)) stat_beats <= stat_beats + 32'd1;
      if (out_valid && !out_ready && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_carry_cmp_pipe.sv
// Self-checking bench for jpeg_carry_cmp_pipe: vector table, stall stream, random stream, mid-flight reset.
module tb_jpeg_carry_cmp_pipe;

  localparam int W      = 16;
  localparam int CH     = 4;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [CH*W-1:0] sum;
    logic [CH-1:0]   cout;
    logic [CH-1:0]   gt;
    logic [CH-1:0]   eq;
    logic [CH-1:0]   par;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         gt;
    logic         eq;
    logic         par;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CH*W-1:0] in_a = '0;
  logic [CH*W-1:0] in_b = '0;
  logic [CH-1:0]   in_cin = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CH*W-1:0] out_sum;
  logic [CH-1:0]   out_cout;
  logic [CH-1:0]   out_gt;
  logic [CH-1:0]   out_eq;
  logic [CH-1:0]   out_par;
`ifdef JPEG_CARRY_STATS_EN
  logic [31:0]     stat_beats;
  logic [31:0]     stat_stall;
`endif

  jpeg_carry_cmp_pipe #(.W(W), .CH(CH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_gt    (out_gt),
    .out_eq    (out_eq),
    .out_par   (out_par)
`ifdef JPEG_CARRY_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  bit   mon_en = 1'b0;
  bit   stall_prev = 1'b0;
  bit   s_acc;
  bit   s_in_ready;
  exp_t hold_val;
  exp_t q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-word unsigned arithmetic and compares per channel.
  function automatic exp_t model(input logic [CH*W-1:0] a, input logic [CH*W-1:0] b,
                                 input logic [CH-1:0] cin);
    exp_t e;
    logic [W:0] s;
    for (int c = 0; c < CH; c++) begin
      s = {1'b0, a[c*W +: W]} + {1'b0, b[c*W +: W]} + (W+1)'(cin[c]);
      e.sum[c*W +: W] = s[W-1:0];
      e.cout[c] = s[W];
      e.gt[c]   = a[c*W +: W] > b[c*W +: W];
      e.eq[c]   = a[c*W +: W] == b[c*W +: W];
      e.par[c]  = ^s;
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    exp_t got;
    @(negedge clk);
    got = {out_sum, out_cout, out_gt, out_eq, out_par};
    if (stall_prev) check("stall_hold", got, hold_val);
    stall_prev = rst_n && out_valid && !out_ready;
    hold_val   = got;
    s_in_ready = in_ready;
    s_acc      = rst_n && in_valid && in_ready;
    if (!rst_n) q.delete();
    else if (mon_en) begin
      if (s_acc) begin
        e = model(in_a, in_b, in_cin);
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out: got beat %h, expected no beat", got);
        end else begin
          e = q.pop_front();
          check("beat", got, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_beat();
    for (int c = 0; c < CH; c++) begin
      in_a[c*W +: W] = W'($urandom);
      in_b[c*W +: W] = ($urandom_range(0, 3) == 0) ? in_a[c*W +: W] : W'($urandom);
    end
    in_cin = CH'($urandom);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   bi;

    vecs[0] = '{a:16'h1234, b:16'h0FED, cin:1'b1, sum:16'h2222, cout:1'b0, gt:1'b1, eq:1'b0, par:1'b0};
    vecs[1] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sum:16'h0000, cout:1'b1, gt:1'b1, eq:1'b0, par:1'b1};
    vecs[2] = '{a:16'hA5A5, b:16'hA5A5, cin:1'b0, sum:16'h4B4A, cout:1'b1, gt:1'b0, eq:1'b1, par:1'b0};
    vecs[3] = '{a:16'h0000, b:16'h0000, cin:1'b1, sum:16'h0001, cout:1'b0, gt:1'b0, eq:1'b1, par:1'b1};
    vecs[4] = '{a:16'h00FF, b:16'h0100, cin:1'b0, sum:16'h01FF, cout:1'b0, gt:1'b0, eq:1'b0, par:1'b1};
    vecs[5] = '{a:16'h0100, b:16'h00FF, cin:1'b0, sum:16'h01FF, cout:1'b0, gt:1'b1, eq:1'b0, par:1'b1};
    vecs[6] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sum:16'hFFFF, cout:1'b1, gt:1'b0, eq:1'b1, par:1'b1};

    // Reset state
    do_reset(3);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_in_ready", 80'(in_ready), 80'd1);
    check("rst_data", {out_sum, out_cout, out_gt, out_eq, out_par}, 80'd0);

    // Vector table: one beat each, latency and result on every channel
    mon_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      in_a = {CH{v.a}};
      in_b = {CH{v.b}};
      in_cin = {CH{v.cin}};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 1; j < STAGES; j++) begin
        check($sformatf("vec%0d_lat%0d_vld", i, j), 80'(out_valid), 80'd0);
        tick();
      end
      check($sformatf("vec%0d_vld", i), 80'(out_valid), 80'd1);
      e.sum = {CH{v.sum}};
      e.cout = {CH{v.cout}};
      e.gt = {CH{v.gt}};
      e.eq = {CH{v.eq}};
      e.par = {CH{v.par}};
      check($sformatf("vec%0d_data", i), {out_sum, out_cout, out_gt, out_eq, out_par}, e);
    end
    tick();

    // Eight back-to-back beats with the sink stalled in cycles 5..7
    do_reset(2);
    mon_en = 1'b1;
    n_out = 0;
    bi = 0;
    for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid = (bi < 8);
      for (int c = 0; c < CH; c++) begin
        in_a[c*W +: W] = W'(bi + 1);
        in_b[c*W +: W] = W'(16'h0100 * c + bi);
      end
      in_cin = CH'(bi);
      tick();
      if (s_acc) bi++;
      if (cyc >= 5 && cyc <= 7) check($sformatf("t4_in_ready_c%0d", cyc), 80'(s_in_ready), 80'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t4_beats_out", 80'(n_out), 80'd8);
    check("t4_queue_empty", 80'(q.size()), 80'd0);
`ifdef JPEG_CARRY_STATS_EN
    check("t4_stat_beats", 80'(stat_beats), 80'd8);
    check("t4_stat_stall", 80'(stat_stall), 80'd3);
`endif

    // Random stream with random backpressure against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && q.size() != 0; cyc++) tick();
    check("rand_drained", 80'(q.size()), 80'd0);

    // Reset with three beats in flight discards them
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    do_reset(1);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("flush_vld%0d", j), 80'(out_valid), 80'd0);
      tick();
    end
    n_out = 0;
    in_valid = 1'b1;
    rand_beat();
    tick();
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 10 && n_out < 1; cyc++) tick();
    check("post_flush_beat", 80'(n_out), 80'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
